exec_sequencer: RTL and testbench
=================================

Name: exec_sequencer

Overview:
- Responder side of the ins_count/ins_done handshake with control_signal.
- Each ins_count pulse starts one instruction. The block steps it through FETCH, DECODE, EXEC and WB, then returns a one-cycle ins_done pulse.
- Drives instruction memory enable, decoder enable, ALU/memory/regfile strobes, and program_counter jump/return controls.
- Sits between the instruction_decoder outputs and the datapath.

Parameters:
- MUL_CYCLES, 4, EXEC-state duration for MUL; legal range 1..15.
- ADDR_WIDTH, 16, width of jump_address; upper bits are zero-filled.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- ins_count  input  1  single-cycle start pulse from control_signal.
- opcode  input  4  decoded opcode; sampled in DECODE.
- reg_a  input  4  decoded field; jump target high nibble.
- reg_b  input  4  decoded field; jump target low nibble.
- zero_flag  input  1  ALU zero flag; sampled in EXEC.
- imem_enable  output  1  instruction memory read enable.
- decode_enable  output  1  decoder register load.
- alu_enable  output  1  ALU operate strobe.
- mem_read  output  1  data memory read strobe.
- mem_write  output  1  data memory write strobe.
- reg_write  output  1  register file write strobe.
- jump_enable  output  1  program_counter load strobe.
- jump_address  output  ADDR_WIDTH  jump target, equal to {zeros, reg_a, reg_b}.
- return_enable  output  1  program_counter return strobe.
- ins_done  output  1  instruction-complete pulse to control_signal.
- busy  output  1  high whenever state is not IDLE or HALTED.
- halted  output  1  high in HALTED.
- overrun  output  1  sticky flag: ins_count arrived while busy.

Behaviour:
- Reset: state=IDLE, cycle counter=0, latched opcode=0. All outputs are 0, including jump_address. Reset overrides every other input, including mid-instruction; no strobe is emitted in the cycle after reset.
- Opcodes: 0x0 NOP, 0x1 ADD, 0x2 SUB, 0x3 AND, 0x4 OR, 0x5 XOR, 0x6 LDI, 0x7 LD, 0x8 ST, 0x9 MUL, 0xA JMP, 0xB JZ, 0xD RET, 0xF HALT. Opcodes 0xC and 0xE are treated as NOP.
- States and transitions:
  - IDLE -> FETCH when ins_count=1.
  - FETCH -> DECODE.
  - DECODE -> EXEC; opcode is latched on this edge.
  - EXEC -> WB, except MUL holds EXEC for MUL_CYCLES cycles and HALT goes to HALTED.
  - WB -> DONE.
  - DONE -> IDLE.
  - HALTED -> HALTED until reset.
- Output decode is Moore, from the registered state and latched opcode:
  - FETCH: imem_enable=1.
  - DECODE: decode_enable=1.
  - EXEC, ALU ops and MUL: alu_enable=1 on every EXEC cycle.
  - EXEC, LD: mem_read=1. ST: mem_write=1.
  - EXEC, JMP: jump_enable=1 for one cycle, with jump_address valid in the same cycle.
  - EXEC, JZ: as JMP, but only when zero_flag=1.
  - EXEC, RET: return_enable=1.
  - WB: reg_write=1 for ADD, SUB, AND, OR, XOR, LDI, LD, MUL only.
  - DONE: ins_done=1.
- Latency: if ins_count is sampled at edge N, ins_done is high in the cycle after edge N+4 for all non-MUL ops, and after edge N+3+MUL_CYCLES for MUL.
- MUL counter:
  - Loaded with MUL_CYCLES-1 on entry to EXEC and decremented each EXEC cycle.
  - EXEC exits when the counter is 0.
  - MUL_CYCLES=1 behaves like a single-cycle op.
- ins_count while busy or halted: ignored (no restart) and overrun is set to 1; overrun clears only on reset.
- ins_count in the DONE cycle also counts as busy: it is ignored and sets overrun. control_signal must wait for ins_done before pulsing again.
- Mutual exclusion: at most one of jump_enable and return_enable is high in any cycle, and each is at most one cycle per instruction.
- HALT: no ins_done is ever issued for HALT; halted=1 and busy=0 from the cycle after EXEC.

Decomposition:
- Shared package vr16_pkg holds:
  - opcode localparams (OP_NOP .. OP_HALT);
  - the 3-bit state encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, DONE=5, HALTED=6;
  - the ADDR_WIDTH default.
- One natural sub-module: opcode_classifier. It is combinational, maps opcode to is_alu / is_mem_rd / is_mem_wr / is_jump / is_cond / is_ret / is_halt / writes_reg, and is reusable by the decoder.

Test Plan:
- Reset, then ins_count pulse with opcode=0x1 (ADD) -> imem_enable, decode_enable, alu_enable, reg_write each high for exactly one cycle in sequence. ins_done is high one cycle after edge N+4. busy is low afterwards.
- MUL_CYCLES=4, opcode=0x9 -> alu_enable high for 4 consecutive cycles, reg_write high once, ins_done after edge N+7.
- opcode=0xA, reg_a=0x3, reg_b=0xC -> jump_enable high for one cycle with jump_address=16'h003C, reg_write=0, ins_done after edge N+4.
- opcode=0xB with zero_flag=0 -> no jump_enable. Repeat with zero_flag=1 -> jump_enable high for one cycle.
- ins_count pulsed again during DECODE of a running ADD -> overrun=1, only one ins_done produced. overrun stays 1 until reset.
- opcode=0xF -> halted=1, no ins_done. A subsequent ins_count sets overrun. Then reset high during a MUL EXEC -> next cycle state=IDLE, all strobes 0, halted=0, overrun=0.

Source files
------------

// File: rtl/exec_sequencer_pkg.sv
// Shared definitions for the vr16 instruction sequencer: opcodes, FSM state
// encoding, opcode class record and the jump-target helper.
package vr16_pkg;

    localparam int ADDR_WIDTH_DEFAULT = 16;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_LD   = 4'h7;
    localparam logic [3:0] OP_ST   = 4'h8;
    localparam logic [3:0] OP_MUL  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_JZ   = 4'hB;
    localparam logic [3:0] OP_RET  = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;
    localparam logic [2:0] ST_HALTED = 3'd6;

    typedef struct packed {
        logic is_alu;
        logic is_mul;
        logic is_mem_rd;
        logic is_mem_wr;
        logic is_jump;
        logic is_cond;
        logic is_ret;
        logic is_halt;
        logic writes_reg;
    } op_class_t;

    function automatic logic [7:0] jump_target(input logic [3:0] hi, input logic [3:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/exec_sequencer_if.sv
// Handshake and control bundle between control_signal/decoder (master side)
// and the execution sequencer (slave side).
interface exec_sequencer_if #(
    parameter int ADDR_WIDTH = vr16_pkg::ADDR_WIDTH_DEFAULT
);
    logic                  ins_count;
    logic [3:0]            opcode;
    logic [3:0]            reg_a;
    logic [3:0]            reg_b;
    logic                  zero_flag;

    logic                  imem_enable;
    logic                  decode_enable;
    logic                  alu_enable;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
    logic                  jump_enable;
    logic [ADDR_WIDTH-1:0] jump_address;
    logic                  return_enable;
    logic                  ins_done;
    logic                  busy;
    logic                  halted;
    logic                  overrun;

    modport master (
        output ins_count, opcode, reg_a, reg_b, zero_flag,
        input  imem_enable, decode_enable, alu_enable, mem_read, mem_write,
               reg_write, jump_enable, jump_address, return_enable,
               ins_done, busy, halted, overrun
    );

    modport slave (
        input  ins_count, opcode, reg_a, reg_b, zero_flag,
        output imem_enable, decode_enable, alu_enable, mem_read, mem_write,
               reg_write, jump_enable, jump_address, return_enable,
               ins_done, busy, halted, overrun
    );
endinterface

// File: rtl/exec_sequencer_opcode_classifier.sv
// Combinational opcode-to-class map; reusable by the instruction decoder.
// Unlisted opcodes (0xC, 0xE) classify as NOP.
module opcode_classifier
    import vr16_pkg::*;
(
    input  logic [3:0] opcode,
    output op_class_t  cls
);

    always_comb begin
        cls = '0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                cls.is_alu     = 1'b1;
                cls.writes_reg = 1'b1;
            end
            OP_LDI: cls.writes_reg = 1'b1;
            OP_LD: begin
                cls.is_mem_rd  = 1'b1;
                cls.writes_reg = 1'b1;
            end
            OP_ST:  cls.is_mem_wr = 1'b1;
            OP_MUL: begin
                cls.is_alu     = 1'b1;
                cls.is_mul     = 1'b1;
                cls.writes_reg = 1'b1;
            end
            OP_JMP: cls.is_jump = 1'b1;
            OP_JZ: begin
                cls.is_jump = 1'b1;
                cls.is_cond = 1'b1;
            end
            OP_RET:  cls.is_ret  = 1'b1;
            OP_HALT: cls.is_halt = 1'b1;
            default: cls = '0;
        endcase
    end

endmodule

// File: rtl/exec_sequencer.sv
// Instruction sequencer: walks each ins_count request through
// FETCH/DECODE/EXEC/WB, then answers with a one-cycle ins_done.
module exec_sequencer
    import vr16_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    exec_sequencer_if.slave bus
);

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] opcode_q, opcode_d;
    logic       overrun_q, overrun_d;

    op_class_t  cls;

    opcode_classifier u_classifier (
        .opcode (opcode_q),
        .cls    (cls)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        opcode_d  = opcode_q;
        // Any request outside IDLE (including DONE and HALTED) is dropped but remembered.
        overrun_d = overrun_q | (bus.ins_count & (state_q != ST_IDLE));
        case (state_q)
            ST_IDLE:   if (bus.ins_count) state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                state_d  = ST_EXEC;
                opcode_d = bus.opcode;
                cnt_d    = MUL_LOAD;
            end
            ST_EXEC: begin
                if (cls.is_mul && (cnt_q != 4'd0)) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (cls.is_halt) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_WB:     state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            opcode_q  <= OP_NOP;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            opcode_q  <= opcode_d;
            overrun_q <= overrun_d;
        end
    end

    logic                  in_exec;
    logic                  jump_fire;
    logic [7:0]            target;
    logic [ADDR_WIDTH-1:0] jump_addr;

    assign in_exec   = (state_q == ST_EXEC);
    // JZ is the only output that also looks at a live input (zero_flag).
    assign jump_fire = in_exec & cls.is_jump & (~cls.is_cond | bus.zero_flag);
    assign target    = jump_target(bus.reg_a, bus.reg_b);

    for (genvar gi = 0; gi < ADDR_WIDTH; gi++) begin : g_jump_addr
        if (gi < 8) begin : g_low
            assign jump_addr[gi] = jump_fire & target[gi];
        end else begin : g_high
            assign jump_addr[gi] = 1'b0;
        end
    end

    assign bus.imem_enable   = (state_q == ST_FETCH);
    assign bus.decode_enable = (state_q == ST_DECODE);
    assign bus.alu_enable    = in_exec & cls.is_alu;
    assign bus.mem_read      = in_exec & cls.is_mem_rd;
    assign bus.mem_write     = in_exec & cls.is_mem_wr;
    assign bus.reg_write     = (state_q == ST_WB) & cls.writes_reg;
    assign bus.jump_enable   = jump_fire;
    assign bus.jump_address  = jump_addr;
    assign bus.return_enable = in_exec & cls.is_ret;
    assign bus.ins_done      = (state_q == ST_DONE);
    assign bus.busy          = (state_q != ST_IDLE) && (state_q != ST_HALTED);
    assign bus.halted        = (state_q == ST_HALTED);
    assign bus.overrun       = overrun_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: opcode table plus hand-written overrun,
// halt and reset-during-MUL sequences. A second instance runs MUL_CYCLES=1.
module tb_exec_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    exec_sequencer_if #(.ADDR_WIDTH(16)) bus ();
    exec_sequencer_if #(.ADDR_WIDTH(16)) bus1 ();

    assign bus1.ins_count = bus.ins_count;
    assign bus1.opcode    = bus.opcode;
    assign bus1.reg_a     = bus.reg_a;
    assign bus1.reg_b     = bus.reg_b;
    assign bus1.zero_flag = bus.zero_flag;

    exec_sequencer #(.MUL_CYCLES(4), .ADDR_WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exec_sequencer #(.MUL_CYCLES(1), .ADDR_WIDTH(16)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int c_imem, c_dec, c_alu, c_rd, c_wr, c_rw, c_jmp, c_ret, c_done, c_addr_bad;
    int done_k, done1_k;
    logic [15:0] cap_addr;

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic        zf;
        int          alu;
        int          rd;
        int          wr;
        int          rw;
        int          jmp;
        int          ret;
        int          done_k;
        int          done1_k;
        logic [15:0] addr;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        c_imem = 0; c_dec = 0; c_alu = 0; c_rd = 0; c_wr = 0; c_rw = 0;
        c_jmp = 0; c_ret = 0; c_done = 0; c_addr_bad = 0;
        done_k = -1; done1_k = -1; cap_addr = 16'h0;
    endtask

    task automatic sample(input int k);
        c_imem += int'(bus.imem_enable);
        c_dec  += int'(bus.decode_enable);
        c_alu  += int'(bus.alu_enable);
        c_rd   += int'(bus.mem_read);
        c_wr   += int'(bus.mem_write);
        c_rw   += int'(bus.reg_write);
        c_jmp  += int'(bus.jump_enable);
        c_ret  += int'(bus.return_enable);
        c_done += int'(bus.ins_done);
        if (bus.jump_enable) cap_addr = bus.jump_address;
        else if (bus.jump_address != 16'h0) c_addr_bad++;
        if (bus.ins_done && done_k < 0) done_k = k;
        if (bus1.ins_done && done1_k < 0) done1_k = k;
        if (bus.jump_enable && bus.return_enable)
            check("jump_ret_exclusive", 32'd1, 32'd0);
    endtask

    task automatic observe(input int k0, input int k1);
        for (int k = k0; k < k1; k++) begin
            sample(k);
            tick();
        end
    endtask

    // Pulse ins_count for one edge; on return the bench sits #1 after that edge (k=0).
    task automatic start_instr(input logic [3:0] op, input logic [3:0] ra,
                               input logic [3:0] rb, input logic zf);
        bus.opcode    = op;
        bus.reg_a     = ra;
        bus.reg_b     = rb;
        bus.zero_flag = zf;
        bus.ins_count = 1'b1;
        tick();
        bus.ins_count = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic check_all_quiet(input string tag);
        check({tag, "_imem"},    32'(bus.imem_enable),   32'd0);
        check({tag, "_dec"},     32'(bus.decode_enable), 32'd0);
        check({tag, "_alu"},     32'(bus.alu_enable),    32'd0);
        check({tag, "_mrd"},     32'(bus.mem_read),      32'd0);
        check({tag, "_mwr"},     32'(bus.mem_write),     32'd0);
        check({tag, "_rw"},      32'(bus.reg_write),     32'd0);
        check({tag, "_jmp"},     32'(bus.jump_enable),   32'd0);
        check({tag, "_jaddr"},   32'(bus.jump_address),  32'd0);
        check({tag, "_ret"},     32'(bus.return_enable), 32'd0);
        check({tag, "_done"},    32'(bus.ins_done),      32'd0);
        check({tag, "_busy"},    32'(bus.busy),          32'd0);
        check({tag, "_halted"},  32'(bus.halted),        32'd0);
        check({tag, "_overrun"}, 32'(bus.overrun),       32'd0);
    endtask

    initial begin
        bus.ins_count = 1'b0;
        bus.opcode    = 4'h0;
        bus.reg_a     = 4'h0;
        bus.reg_b     = 4'h0;
        bus.zero_flag = 1'b0;

        //          op     ra    rb    zf  alu rd wr rw jmp ret dk d1k addr
        vecs[0]  = '{4'h0, 4'h3, 4'hC, 0,  0, 0, 0, 0, 0, 0, 4, 4, 16'h0000};
        vecs[1]  = '{4'h1, 4'h3, 4'hC, 0,  1, 0, 0, 1, 0, 0, 4, 4, 16'h0000};
        vecs[2]  = '{4'h2, 4'h3, 4'hC, 0,  1, 0, 0, 1, 0, 0, 4, 4, 16'h0000};
        vecs[3]  = '{4'h5, 4'h3, 4'hC, 1,  1, 0, 0, 1, 0, 0, 4, 4, 16'h0000};
        vecs[4]  = '{4'h7, 4'h3, 4'hC, 0,  0, 1, 0, 1, 0, 0, 4, 4, 16'h0000};
        vecs[5]  = '{4'h8, 4'h3, 4'hC, 0,  0, 0, 1, 0, 0, 0, 4, 4, 16'h0000};
        vecs[6]  = '{4'h9, 4'h3, 4'hC, 0,  4, 0, 0, 1, 0, 0, 7, 4, 16'h0000};
        vecs[7]  = '{4'hA, 4'h3, 4'hC, 0,  0, 0, 0, 0, 1, 0, 4, 4, 16'h003C};
        vecs[8]  = '{4'hB, 4'h3, 4'hC, 0,  0, 0, 0, 0, 0, 0, 4, 4, 16'h0000};
        vecs[9]  = '{4'hB, 4'hA, 4'h5, 1,  0, 0, 0, 0, 1, 0, 4, 4, 16'h00A5};
        vecs[10] = '{4'hD, 4'h3, 4'hC, 0,  0, 0, 0, 0, 0, 1, 4, 4, 16'h0000};
        vecs[11] = '{4'hC, 4'h3, 4'hC, 0,  0, 0, 0, 0, 0, 0, 4, 4, 16'h0000};
        vecs[12] = '{4'hE, 4'h3, 4'hC, 1,  0, 0, 0, 0, 0, 0, 4, 4, 16'h0000};

        tick();
        tick();
        do_reset();
        check_all_quiet("reset");

        foreach (vecs[i]) begin
            start_instr(vecs[i].op, vecs[i].ra, vecs[i].rb, vecs[i].zf);
            clear_counts();
            observe(0, 12);
            check("imem_count",  32'(c_imem), 32'd1);
            check("dec_count",   32'(c_dec),  32'd1);
            check("alu_count",   32'(c_alu),  32'(vecs[i].alu));
            check("mrd_count",   32'(c_rd),   32'(vecs[i].rd));
            check("mwr_count",   32'(c_wr),   32'(vecs[i].wr));
            check("rw_count",    32'(c_rw),   32'(vecs[i].rw));
            check("jmp_count",   32'(c_jmp),  32'(vecs[i].jmp));
            check("ret_count",   32'(c_ret),  32'(vecs[i].ret));
            check("done_count",  32'(c_done), 32'd1);
            check("done_lat",    32'(done_k), 32'(vecs[i].done_k));
            check("done_lat_mc1", 32'(done1_k), 32'(vecs[i].done1_k));
            check("jaddr_value", 32'(cap_addr), 32'(vecs[i].addr));
            check("jaddr_idle_zero", 32'(c_addr_bad), 32'd0);
            check("busy_after",  32'(bus.busy), 32'd0);
            $display("txn op=%h zf=%0d alu=%0d rw=%0d jmp=%0d ret=%0d done_k=%0d done1_k=%0d addr=%h",
                     vecs[i].op, vecs[i].zf, c_alu, c_rw, c_jmp, c_ret, done_k, done1_k, cap_addr);
        end

        // ins_count in the DONE cycle is dropped and flagged.
        check("overrun_clear_before", 32'(bus.overrun), 32'd0);
        start_instr(4'h1, 4'h0, 4'h0, 1'b0);
        clear_counts();
        observe(0, 4);
        sample(4);
        check("done_at_k4", 32'(bus.ins_done), 32'd1);
        bus.ins_count = 1'b1;
        tick();
        bus.ins_count = 1'b0;
        observe(5, 12);
        check("done_cycle_no_restart", 32'(c_imem), 32'd1);
        check("done_cycle_overrun", 32'(bus.overrun), 32'd1);
        $display("txn done-cycle overlap imem=%0d overrun=%0d", c_imem, bus.overrun);

        // ins_count during DECODE of a running ADD.
        do_reset();
        start_instr(4'h1, 4'h0, 4'h0, 1'b0);
        clear_counts();
        sample(0);
        tick();
        sample(1);
        check("in_decode", 32'(bus.decode_enable), 32'd1);
        bus.ins_count = 1'b1;
        tick();
        bus.ins_count = 1'b0;
        observe(2, 12);
        check("ovr_single_done", 32'(c_done), 32'd1);
        check("ovr_done_lat", 32'(done_k), 32'd4);
        check("ovr_single_fetch", 32'(c_imem), 32'd1);
        check("ovr_flag", 32'(bus.overrun), 32'd1);
        start_instr(4'h0, 4'h0, 4'h0, 1'b0);
        clear_counts();
        observe(0, 8);
        check("ovr_sticky", 32'(bus.overrun), 32'd1);
        $display("txn decode overlap dones=%0d overrun=%0d", c_done, bus.overrun);

        // HALT: no done, halted from the cycle after EXEC, further requests flagged.
        do_reset();
        start_instr(4'hF, 4'h0, 4'h0, 1'b0);
        clear_counts();
        observe(0, 3);
        check("halt_halted", 32'(bus.halted), 32'd1);
        check("halt_not_busy", 32'(bus.busy), 32'd0);
        observe(3, 12);
        check("halt_no_done", 32'(c_done), 32'd0);
        check("halt_overrun_before", 32'(bus.overrun), 32'd0);
        bus.ins_count = 1'b1;
        tick();
        bus.ins_count = 1'b0;
        check("halt_overrun", 32'(bus.overrun), 32'd1);
        check("halt_stays", 32'(bus.halted), 32'd1);
        check("halt_no_fetch", 32'(bus.imem_enable), 32'd0);
        do_reset();
        check("halt_reset_halted", 32'(bus.halted), 32'd0);
        check("halt_reset_overrun", 32'(bus.overrun), 32'd0);
        $display("txn halt dones=%0d", c_done);

        // Reset in the middle of a MUL EXEC phase.
        start_instr(4'h9, 4'h0, 4'h0, 1'b0);
        observe(0, 3);
        check("mul_exec_alu", 32'(bus.alu_enable), 32'd1);
        bus.ins_count = 1'b1;
        tick();
        bus.ins_count = 1'b0;
        check("mul_overrun", 32'(bus.overrun), 32'd1);
        check("mul_still_exec", 32'(bus.alu_enable), 32'd1);
        do_reset();
        check_all_quiet("mulrst");
        clear_counts();
        observe(0, 8);
        check("mulrst_no_strobes", 32'(c_alu + c_rw + c_done + c_imem), 32'd0);
        $display("txn reset during MUL exec strobes=%0d", c_alu + c_rw + c_done + c_imem);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
